cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 42 ++++
 rtl/cdb_src_fifo.sv | 66 ++++++
 rtl/cdb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter: field widths,
// CDB lane layout, source indices and the round-robin index helper.
package cdb_arbiter_pkg;

    localparam int TAG_W          = 4;
    localparam int DATA_W         = 32;
    localparam int CDB_W          = 74;
    localparam int SRC_FIFO_DEPTH = 4;
    localparam int NUM_SRC        = 3;
    localparam int CNT_W          = 3;
    localparam int PTR_W          = 2;

    // Lane layout on the CDB: each lane is {valid, tag, value}.
    localparam int LANE0_VALUE_LO = 0;
    localparam int LANE0_TAG_LO   = 32;
    localparam int LANE0_VALID    = 36;
    localparam int LANE1_VALUE_LO = 37;
    localparam int LANE1_TAG_LO   = 69;
    localparam int LANE1_VALID    = 73;

    typedef logic [1:0] src_idx_t;

    localparam src_idx_t SRC_ALU = 2'd0;
    localparam src_idx_t SRC_LSB = 2'd1;
    localparam src_idx_t SRC_BRU = 2'd2;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_entry_t;

    // (base + step) mod NUM_SRC for base, step in 0..2.
    function automatic src_idx_t src_add(input src_idx_t base, input src_idx_t step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            return src_idx_t'(sum - 3'd3);
        end
        return src_idx_t'(sum);
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source 4-entry result FIFO. Pops (one or two) are applied before the
// push, so a full FIFO still accepts a push in a cycle where it is popped.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             push,
    input  cdb_entry_t       push_data,
    input  logic             pop1,
    input  logic             pop2,
    output cdb_entry_t       head,
    output cdb_entry_t       head_next,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             drop
);

    cdb_entry_t       mem [SRC_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] after_pop;
    logic             accept;

    always_comb begin
        pop_cnt    = pop2 ? 3'd2 : (pop1 ? 3'd1 : 3'd0);
        after_pop  = count - pop_cnt;
        accept     = push && !clear && (after_pop < CNT_W'(SRC_FIFO_DEPTH));
        // A flush discards pushes silently; only capacity losses are drops.
        drop       = push && !clear && !accept;
        count_next = clear ? '0 : after_pop + {2'b00, accept};
    end

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + 2'd1];

    always_ff @(posedge clk) begin
        if (en && accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + pop_cnt[PTR_W-1:0];
                if (accept) begin
                    wr_ptr <= wr_ptr + 2'd1;
                end
                count <= count_next;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-lane common data bus arbiter: ALU, LSB and BRU results are queued per
// source and granted round-robin onto a registered two-lane CDB.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_value,
    input  logic              bru_valid,
    input  logic [TAG_W-1:0]  bru_tag,
    input  logic [DATA_W-1:0] bru_value,
    output logic              alu_ready,
    output logic              lsb_ready,
    output logic              bru_ready,
    output logic [CDB_W-1:0]  cdb,
    output logic              overflow,
    output logic [1:0]        rr_dbg
);

    // Handshake: x_valid pushes unconditionally; x_ready is advisory and is
    // only high while at least two slots are free, so a producer that reacts
    // one cycle late still never loses an entry. Each cdb lane is a one-cycle
    // valid pulse with no back-pressure.

    logic [NUM_SRC-1:0]            push_v;
    cdb_entry_t [NUM_SRC-1:0]      push_e;
    cdb_entry_t [NUM_SRC-1:0]      head;
    cdb_entry_t [NUM_SRC-1:0]      head_next;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_nxt;
    logic [NUM_SRC-1:0]            pop1;
    logic [NUM_SRC-1:0]            pop2;
    logic [NUM_SRC-1:0]            drop;

    src_idx_t         rr_q;
    logic [CDB_W-1:0] cdb_q;
    logic [CDB_W-1:0] cdb_next;
    logic             overflow_q;
    logic [NUM_SRC-1:0] ready_q;

    src_idx_t   cand;
    logic       g0_v;
    src_idx_t   g0_src;
    logic       g1_v;
    src_idx_t   g1_src;
    logic       g1_same;
    src_idx_t   last_src;
    cdb_entry_t lane0_e;
    cdb_entry_t lane1_e;

    always_comb begin
        push_v              = '0;
        push_e              = '0;
        push_v[SRC_ALU]     = alu_valid;
        push_e[SRC_ALU]     = '{tag: alu_tag, value: alu_value};
        push_v[SRC_LSB]     = lsb_valid;
        push_e[SRC_LSB]     = '{tag: lsb_tag, value: lsb_value};
        push_v[SRC_BRU]     = bru_valid;
        push_e[SRC_BRU]     = '{tag: bru_tag, value: bru_value};
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
        cdb_src_fifo u_fifo (
            .clk        (clk),
            .rst        (rst),
            .en         (rdy),
            .clear      (flush),
            .push       (push_v[s]),
            .push_data  (push_e[s]),
            .pop1       (pop1[s]),
            .pop2       (pop2[s]),
            .head       (head[s]),
            .head_next  (head_next[s]),
            .count      (cnt[s]),
            .count_next (cnt_nxt[s]),
            .drop       (drop[s])
        );
    end

    // Scan rr, rr+1, rr+2: first non-empty source takes lane0, the next one
    // lane1; with a single busy source its second entry fills lane1.
    always_comb begin
        cand    = rr_q;
        g0_v    = 1'b0;
        g0_src  = rr_q;
        g1_v    = 1'b0;
        g1_src  = rr_q;
        g1_same = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = src_add(rr_q, src_idx_t'(k));
            if (cnt[cand] != '0) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_src = cand;
                end else if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_src = cand;
                end
            end
        end
        if (g0_v && !g1_v && (cnt[g0_src] >= 3'd2)) begin
            g1_v    = 1'b1;
            g1_src  = g0_src;
            g1_same = 1'b1;
        end
        last_src = g1_v ? g1_src : g0_src;
        lane0_e  = head[g0_src];
        lane1_e  = g1_same ? head_next[g0_src] : head[g1_src];
    end

    always_comb begin
        pop1 = '0;
        pop2 = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            pop2[s] = g1_same && (g0_src == src_idx_t'(s));
            pop1[s] = !pop2[s] &&
                      ((g0_v && (g0_src == src_idx_t'(s))) ||
                       (g1_v && !g1_same && (g1_src == src_idx_t'(s))));
        end
    end

    always_comb begin
        cdb_next = '0;
        if (g0_v) begin
            cdb_next[LANE0_VALID]                = 1'b1;
            cdb_next[LANE0_TAG_LO +: TAG_W]      = lane0_e.tag;
            cdb_next[LANE0_VALUE_LO +: DATA_W]   = lane0_e.value;
        end
        if (g1_v) begin
            cdb_next[LANE1_VALID]                = 1'b1;
            cdb_next[LANE1_TAG_LO +: TAG_W]      = lane1_e.tag;
            cdb_next[LANE1_VALUE_LO +: DATA_W]   = lane1_e.value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= SRC_ALU;
            cdb_q      <= '0;
            overflow_q <= 1'b0;
            ready_q    <= '1;
        end else if (rdy) begin
            if (flush) begin
                rr_q    <= SRC_ALU;
                cdb_q   <= '0;
                ready_q <= '1;
            end else begin
                cdb_q      <= cdb_next;
                overflow_q <= overflow_q | (|drop);
                if (g0_v) begin
                    rr_q <= src_add(last_src, 2'd1);
                end
                for (int s = 0; s < NUM_SRC; s++) begin
                    ready_q[s] <= (cnt_nxt[s] <= 3'd2);
                end
            end
        end
    end

    assign cdb       = cdb_q;
    assign overflow  = overflow_q;
    assign alu_ready = ready_q[SRC_ALU];
    assign lsb_ready = ready_q[SRC_LSB];
    assign bru_ready = ready_q[SRC_BRU];
    assign rr_dbg    = rr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter, checked every cycle against a
// queue-based model of the per-source buffers and the round-robin grant rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              alu_valid;
    logic [TAG_W-1:0]  alu_tag;
    logic [DATA_W-1:0] alu_value;
    logic              lsb_valid;
    logic [TAG_W-1:0]  lsb_tag;
    logic [DATA_W-1:0] lsb_value;
    logic              bru_valid;
    logic [TAG_W-1:0]  bru_tag;
    logic [DATA_W-1:0] bru_value;
    logic              alu_ready;
    logic              lsb_ready;
    logic              bru_ready;
    logic [CDB_W-1:0]  cdb;
    logic              overflow;
    logic [1:0]        rr_dbg;

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_tag   (alu_tag),
        .alu_value (alu_value),
        .lsb_valid (lsb_valid),
        .lsb_tag   (lsb_tag),
        .lsb_value (lsb_value),
        .bru_valid (bru_valid),
        .bru_tag   (bru_tag),
        .bru_value (bru_value),
        .alu_ready (alu_ready),
        .lsb_ready (lsb_ready),
        .bru_ready (bru_ready),
        .cdb       (cdb),
        .overflow  (overflow),
        .rr_dbg    (rr_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int checks   = 0;
    int failures = 0;

    logic [CDB_W-1:0] exp_q [$];
    logic [35:0]      q_src0 [$];
    logic [35:0]      q_src1 [$];
    logic [35:0]      q_src2 [$];
    int               m_rr;
    logic             m_ovf;
    logic [2:0]       m_ready;
    logic [CDB_W-1:0] m_cdb;

    function automatic int q_size(input int s);
        case (s)
            0:       return q_src0.size();
            1:       return q_src1.size();
            default: return q_src2.size();
        endcase
    endfunction

    function automatic logic [35:0] q_pop(input int s);
        case (s)
            0:       return q_src0.pop_front();
            1:       return q_src1.pop_front();
            default: return q_src2.pop_front();
        endcase
    endfunction

    function automatic void q_push(input int s, input logic [35:0] e);
        case (s)
            0:       q_src0.push_back(e);
            1:       q_src1.push_back(e);
            default: q_src2.push_back(e);
        endcase
    endfunction

    function automatic void q_clear();
        q_src0.delete();
        q_src1.delete();
        q_src2.delete();
    endfunction

    // A buffered push is accepted when the queue holds fewer than 4 after
    // this cycle's grants; otherwise it is lost and overflow latches.
    function automatic void model_push(input int s, input logic v, input logic [35:0] e);
        if (v) begin
            if (q_size(s) < 4) q_push(s, e);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic model_step();
        int               order [$];
        int               s;
        logic [CDB_W-1:0] c;
        if (rst) begin
            q_clear();
            m_rr    = 0;
            m_ovf   = 1'b0;
            m_ready = 3'b111;
            m_cdb   = '0;
        end else if (rdy) begin
            if (flush) begin
                q_clear();
                m_rr    = 0;
                m_ready = 3'b111;
                m_cdb   = '0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    s = (m_rr + k) % 3;
                    if (q_size(s) > 0) order.push_back(s);
                end
                c = '0;
                if (order.size() >= 2) begin
                    c[36:0]  = {1'b1, q_pop(order[0])};
                    c[73:37] = {1'b1, q_pop(order[1])};
                    m_rr = (order[1] + 1) % 3;
                end else if (order.size() == 1) begin
                    c[36:0] = {1'b1, q_pop(order[0])};
                    if (q_size(order[0]) > 0) c[73:37] = {1'b1, q_pop(order[0])};
                    m_rr = (order[0] + 1) % 3;
                end
                m_cdb = c;
                model_push(0, alu_valid, {alu_tag, alu_value});
                model_push(1, lsb_valid, {lsb_tag, lsb_value});
                model_push(2, bru_valid, {bru_tag, bru_value});
                for (int k = 0; k < 3; k++) m_ready[k] = (q_size(k) <= 2);
            end
        end
        exp_q.push_back(m_cdb);
    endtask

    // Tag/value are don't-care on an invalid lane.
    function automatic logic [CDB_W-1:0] mask_cdb(input logic [CDB_W-1:0] x);
        logic [CDB_W-1:0] r;
        r = x;
        if (!r[36]) r[35:0] = '0;
        if (!r[73]) r[72:37] = '0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [CDB_W-1:0] obs, input logic [CDB_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [CDB_W-1:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("cdb", mask_cdb(cdb), mask_cdb(e));
        chk("ready", CDB_W'({bru_ready, lsb_ready, alu_ready}), CDB_W'(m_ready));
        chk("overflow", CDB_W'(overflow), CDB_W'(m_ovf));
        chk("rr", CDB_W'(rr_dbg), CDB_W'(m_rr));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        flush     = 1'b0;
        alu_valid = 1'b0; alu_tag = '0; alu_value = '0;
        lsb_valid = 1'b0; lsb_tag = '0; lsb_value = '0;
        bru_valid = 1'b0; bru_tag = '0; bru_value = '0;
    endtask

    task automatic drive(input int s, input logic [3:0] t, input logic [31:0] d);
        case (s)
            0:       begin alu_valid = 1'b1; alu_tag = t; alu_value = d; end
            1:       begin lsb_valid = 1'b1; lsb_tag = t; lsb_value = d; end
            default: begin bru_valid = 1'b1; bru_tag = t; bru_value = d; end
        endcase
    endtask

    task automatic drive_random(input int pct);
        for (int s = 0; s < 3; s++) begin
            if ($urandom_range(0, 99) < pct)
                drive(s, 4'($urandom_range(0, 15)), $urandom);
        end
    endtask

    // One clock: DUT and model both update on the edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();
        step();
        step();
        chk("reset_cdb", cdb, '0);
        chk("reset_ready", CDB_W'({bru_ready, lsb_ready, alu_ready}), CDB_W'(3'b111));
        rst = 1'b0;

        // single ALU push reaches lane0 two cycles later
        drive(0, 4'd3, 32'h11);
        step();
        idle_inputs();
        step();
        chk("single_lane0", CDB_W'(cdb[36:0]), CDB_W'({1'b1, 4'd3, 32'h11}));
        chk("single_lane1_v", CDB_W'(cdb[73]), '0);
        step();

        // three sources at once from rr=0
        flush = 1'b1;
        step();
        idle_inputs();
        drive(0, 4'd1, 32'hA1);
        drive(1, 4'd2, 32'hB2);
        drive(2, 4'd3, 32'hC3);
        step();
        idle_inputs();
        step();
        chk("three_lane0", CDB_W'(cdb[36:32]), CDB_W'({1'b1, 4'd1}));
        chk("three_lane1", CDB_W'(cdb[73:69]), CDB_W'({1'b1, 4'd2}));
        step();
        chk("three_second_lane0", CDB_W'(cdb[36:32]), CDB_W'({1'b1, 4'd3}));
        chk("three_second_lane1_v", CDB_W'(cdb[73]), '0);
        step();

        // five back-to-back ALU pushes
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            drive(0, 4'(i + 4), 32'(i * 3 + 1));
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        chk("burst_no_overflow", CDB_W'(overflow), '0);

        // all three sources saturated until something is dropped
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            drive_random(100);
            step();
        end
        chk("saturate_overflow", CDB_W'(overflow), CDB_W'(1'b1));

        // flush with entries queued and a same-cycle push
        idle_inputs();
        flush = 1'b1;
        step();
        idle_inputs();
        drive(0, 4'd7, 32'h70);
        drive(1, 4'd8, 32'h80);
        drive(2, 4'd9, 32'h90);
        step();
        idle_inputs();
        drive(1, 4'd10, 32'hA0);
        flush = 1'b1;
        step();
        chk("flush_valids", CDB_W'({cdb[73], cdb[36]}), '0);
        idle_inputs();
        for (int i = 0; i < 3; i++) step();

        // stall mid-drain: pushes and flush ignored while rdy is low
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            drive(0, 4'(i), 32'(i + 100));
            drive(1, 4'(i + 8), 32'(i + 200));
            step();
        end
        idle_inputs();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            drive_random(80);
            flush = 1'($urandom_range(0, 1));
            step();
        end
        idle_inputs();
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // randomized traffic
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            drive_random((i / 100) % 2 == 0 ? 45 : 80);
            flush = ($urandom_range(0, 29) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 249) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
